// File: rtl/hazard_fwd_ctrl.sv
// Unified hazard/forwarding controller for the 5-stage pipeline: scoreboard of in-flight
// destinations, registered EX forwarding selects, load-use stall, redirect flush. Optional: HAZ_PERF_CNT_EN.
module hazard_fwd_ctrl #(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_LAT   = 2,
    parameter int BR_PENALTY = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              id_valid,
    input  logic [REG_AW-1:0]                 id_rs1,
    input  logic [REG_AW-1:0]                 id_rs2,
    input  logic                              id_rs1_used,
    input  logic                              id_rs2_used,
    input  logic [REG_AW-1:0]                 id_rd,
    input  logic                              id_rw,
    input  logic                              id_is_load,
    input  logic                              ex_redirect,
    output logic                              stall_o,
    output logic                              flush_o,
    output logic [$clog2(FWD_STAGES+1)-1:0]   fwd_sel_a_ex,
    output logic [$clog2(FWD_STAGES+1)-1:0]   fwd_sel_b_ex
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]                       perf_stall_cnt,
    output logic [31:0]                       perf_flush_cnt
`endif
);

    localparam int SEL_W = $clog2(FWD_STAGES + 1);
    localparam int CNT_W = $clog2(BR_PENALTY + 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BR_PENALTY - 1);

    typedef struct packed {
        logic             hit;
        logic             hazard;
        logic [SEL_W-1:0] sel;
    } match_t;

    // Index 0 is the EX stage; higher indices are older instructions.
    logic [FWD_STAGES-1:0]             sb_valid_r;
    logic [FWD_STAGES-1:0]             sb_load_r;
    logic [FWD_STAGES-1:0][REG_AW-1:0] sb_rd_r;

    logic [CNT_W-1:0] flush_cnt_r;
    logic [CNT_W-1:0] flush_cnt_nxt_s;
    logic [SEL_W-1:0] fwd_sel_a_r;
    logic [SEL_W-1:0] fwd_sel_b_r;

    logic             flush_s;
    logic             stall_s;
    logic             issue_s;
    logic             ins_valid_s;
    logic             ins_load_s;
    logic [REG_AW-1:0] ins_rd_s;
    match_t           match_a_s;
    match_t           match_b_s;

    // Nearest producer of a source among the forwardable stages; the loop runs oldest
    // first so the youngest matching entry overwrites any older one.
    function automatic match_t find_match(
        input logic                              used,
        input logic [REG_AW-1:0]                 src,
        input logic [FWD_STAGES-1:0]             vld,
        input logic [FWD_STAGES-1:0]             ld,
        input logic [FWD_STAGES-1:0][REG_AW-1:0] rd
    );
        match_t m;
        m.hit    = 1'b0;
        m.hazard = 1'b0;
        m.sel    = {SEL_W{1'b0}};
        for (int j = FWD_STAGES - 2; j >= 0; j--) begin
            if (used && (src != {REG_AW{1'b0}}) && vld[j] && (rd[j] == src)) begin
                m.hit    = 1'b1;
                m.hazard = ld[j] && ((j + 1) < LOAD_LAT);
                m.sel    = SEL_W'(j + 2);
            end
        end
        return m;
    endfunction

    // Source matching against the scoreboard
    always_comb begin
        match_a_s = find_match(id_rs1_used, id_rs1, sb_valid_r, sb_load_r, sb_rd_r);
        match_b_s = find_match(id_rs2_used, id_rs2, sb_valid_r, sb_load_r, sb_rd_r);
    end

    // Flush has priority: a squashed ID instruction can never stall
    always_comb begin
        flush_s = ex_redirect | (flush_cnt_r != {CNT_W{1'b0}});
        if (flush_s) begin
            stall_s = 1'b0;
        end else begin
            stall_s = id_valid & (match_a_s.hazard | match_b_s.hazard);
        end
        issue_s = id_valid & ~stall_s & ~flush_s;
    end

    // Entry written into the EX slot of the scoreboard (bubble unless ID issues)
    always_comb begin
        ins_valid_s = 1'b0;
        ins_load_s  = 1'b0;
        ins_rd_s    = {REG_AW{1'b0}};
        if (issue_s) begin
            ins_valid_s = id_rw & (id_rd != {REG_AW{1'b0}});
            ins_load_s  = id_is_load;
            ins_rd_s    = id_rd;
        end else begin
            ins_valid_s = 1'b0;
        end
    end

    // Redirect counter: a redirect seen while a window is open belongs to squashed EX contents
    always_comb begin
        flush_cnt_nxt_s = flush_cnt_r;
        if (flush_cnt_r != {CNT_W{1'b0}}) begin
            flush_cnt_nxt_s = flush_cnt_r - CNT_ONE;
        end else if (ex_redirect) begin
            flush_cnt_nxt_s = CNT_RELOAD;
        end else begin
            flush_cnt_nxt_s = {CNT_W{1'b0}};
        end
    end

    // Scoreboard shift, registered forwarding selects and flush counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            sb_valid_r  <= {FWD_STAGES{1'b0}};
            sb_load_r   <= {FWD_STAGES{1'b0}};
            sb_rd_r     <= {(FWD_STAGES*REG_AW){1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
            fwd_sel_a_r <= {SEL_W{1'b0}};
            fwd_sel_b_r <= {SEL_W{1'b0}};
        end else begin
            sb_valid_r  <= {sb_valid_r[FWD_STAGES-2:0], ins_valid_s};
            sb_load_r   <= {sb_load_r[FWD_STAGES-2:0], ins_load_s};
            sb_rd_r     <= {sb_rd_r[FWD_STAGES-2:0], ins_rd_s};
            flush_cnt_r <= flush_cnt_nxt_s;
            fwd_sel_a_r <= issue_s ? match_a_s.sel : {SEL_W{1'b0}};
            fwd_sel_b_r <= issue_s ? match_b_s.sel : {SEL_W{1'b0}};
        end
    end

    assign stall_o      = stall_s;
    assign flush_o      = flush_s;
    assign fwd_sel_a_ex = fwd_sel_a_r;
    assign fwd_sel_b_ex = fwd_sel_b_r;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_cnt_r;
    logic [31:0] perf_flush_cnt_r;

    // Free-running stall/flush cycle counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_cnt_r <= 32'd0;
            perf_flush_cnt_r <= 32'd0;
        end else begin
            perf_stall_cnt_r <= perf_stall_cnt_r + {31'd0, stall_s};
            perf_flush_cnt_r <= perf_flush_cnt_r + {31'd0, flush_s};
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_r;
    assign perf_flush_cnt = perf_flush_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: a per-register last-writer model predicts each cycle's
// outputs, the driver queues them and an independent monitor compares against the DUT.
module tb_hazard_fwd_ctrl;
    localparam int AW   = 5;
    localparam int FS   = 3;
    localparam int LL   = 2;
    localparam int BP   = 2;
    localparam int SW   = $clog2(FS + 1);
    localparam int NREG = 1 << AW;
    localparam int NEVER = -1000;

    logic          clk;
    logic          reset;
    logic          id_valid;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic          id_rs1_used;
    logic          id_rs2_used;
    logic [AW-1:0] id_rd;
    logic          id_rw;
    logic          id_is_load;
    logic          ex_redirect;
    logic          stall_o;
    logic          flush_o;
    logic [SW-1:0] fwd_sel_a_ex;
    logic [SW-1:0] fwd_sel_b_ex;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]   perf_stall_cnt;
    logic [31:0]   perf_flush_cnt;
`endif

    hazard_fwd_ctrl #(.REG_AW(AW), .FWD_STAGES(FS), .LOAD_LAT(LL), .BR_PENALTY(BP)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rw(id_rw),
        .id_is_load(id_is_load), .ex_redirect(ex_redirect), .stall_o(stall_o), .flush_o(flush_o),
        .fwd_sel_a_ex(fwd_sel_a_ex), .fwd_sel_b_ex(fwd_sel_b_ex)
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          stall;
        logic          flush;
        logic [SW-1:0] sa;
        logic [SW-1:0] sb;
        int unsigned   ps;
        int unsigned   pf;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;

    // Reference model: per register, the cycle its youngest producer issued and whether it was a load
    int          last_wr[NREG];
    logic        last_ld[NREG];
    int          flush_end;
    int          t;
    logic [SW-1:0] m_sel_a;
    logic [SW-1:0] m_sel_b;
    logic        m_stall;
    int unsigned m_ps;
    int unsigned m_pf;

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            last_wr[i] = NEVER;
            last_ld[i] = 1'b0;
        end
        flush_end = NEVER;
        m_sel_a   = '0;
        m_sel_b   = '0;
        m_ps      = 0;
        m_pf      = 0;
    endtask

    // A producer issued at cycle c sits j = t-c-1 stages past EX; forwardable while j <= FS-2
    task automatic lookup(input logic used, input logic [AW-1:0] src,
                          output logic hit, output logic haz, output logic [SW-1:0] sel);
        int age;
        hit = 1'b0;
        haz = 1'b0;
        sel = '0;
        if (used && src != '0 && last_wr[src] != NEVER) begin
            age = t - last_wr[src] - 1;
            if (age <= FS - 2) begin
                hit = 1'b1;
                haz = last_ld[src] && (age + 1 < LL);
                sel = SW'(age + 2);
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [AW-1:0] r1, input logic u1,
                       input logic [AW-1:0] r2, input logic u2, input logic [AW-1:0] rd,
                       input logic rw, input logic ld, input logic redir, input logic rstn);
        exp_t e;
        logic flushing, fl, st, iss, ha, hb, za, zb;
        logic [SW-1:0] sa, sb;
        @(negedge clk);
        id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
        id_rd = rd; id_rw = rw; id_is_load = ld; ex_redirect = redir; reset = rstn;
        flushing = (t <= flush_end);
        fl = redir | flushing;
        lookup(u1, r1, ha, za, sa);
        lookup(u2, r2, hb, zb, sb);
        st = v & ~fl & (za | zb);
        e.stall = st; e.flush = fl; e.sa = m_sel_a; e.sb = m_sel_b;
        e.ps = m_ps; e.pf = m_pf; e.cyc = t;
        exp_q.push_back(e);
        m_stall = st;
        iss = v & ~st & ~fl;
        if (redir && !flushing) flush_end = t + BP - 1;
        m_sel_a = (iss && ha) ? sa : '0;
        m_sel_b = (iss && hb) ? sb : '0;
        if (iss && rw && rd != '0) begin
            last_wr[rd] = t;
            last_ld[rd] = ld;
        end
        if (st) m_ps++;
        if (fl) m_pf++;
        if (!rstn) model_reset();
        t++;
    endtask

    // Present an instruction in ID, holding it there for as long as the model predicts a stall
    task automatic issue(input logic [AW-1:0] rd, input logic ld, input logic [AW-1:0] r1,
                         input logic u1, input logic [AW-1:0] r2, input logic u2);
        int tries = 0;
        do begin
            cyc(1'b1, r1, u1, r2, u2, rd, 1'b1, ld, 1'b0, 1'b1);
            tries++;
        end while (m_stall && tries < 8);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-low-phase after inputs settle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall_o", e.cyc, 32'(stall_o), 32'(e.stall));
                chk("flush_o", e.cyc, 32'(flush_o), 32'(e.flush));
                chk("fwd_sel_a", e.cyc, 32'(fwd_sel_a_ex), 32'(e.sa));
                chk("fwd_sel_b", e.cyc, 32'(fwd_sel_b_ex), 32'(e.sb));
`ifdef HAZ_PERF_CNT_EN
                chk("perf_stall", e.cyc, perf_stall_cnt, e.ps);
                chk("perf_flush", e.cyc, perf_flush_cnt, e.pf);
`endif
            end
        end
    end

    initial begin
        logic [AW-1:0] r1, r2, rd;
        logic u1, u2, v, rw, ld;
        total = 0; bad = 0; t = 0; m_stall = 1'b0;
        model_reset();
        reset = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0;
        id_rs2_used = 1'b0; id_rd = '0; id_rw = 1'b0; id_is_load = 1'b0; ex_redirect = 1'b0;
        cyc(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        // back-to-back ALU dependency
        issue(5'd5, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
        issue(5'd6, 1'b0, 5'd5, 1'b1, 5'd3, 1'b1);
        idle(3);
        // distance 2, then distance 3
        issue(5'd5, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
        issue(5'd8, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
        issue(5'd9, 1'b0, 5'd3, 1'b1, 5'd5, 1'b1);
        idle(3);
        issue(5'd5, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
        issue(5'd8, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
        issue(5'd10, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
        issue(5'd9, 1'b0, 5'd3, 1'b1, 5'd5, 1'b1);
        idle(3);
        // load-use
        issue(5'd7, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);
        issue(5'd11, 1'b0, 5'd7, 1'b1, 5'd2, 1'b1);
        idle(3);
        // x0 and unused-source filtering
        issue(5'd0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1);
        issue(5'd11, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
        issue(5'd12, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1);
        issue(5'd13, 1'b0, 5'd1, 1'b1, 5'd12, 1'b0);
        idle(3);
        // same register on both sources, through a load
        issue(5'd14, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1);
        issue(5'd15, 1'b0, 5'd14, 1'b1, 5'd14, 1'b1);
        idle(3);
        // redirect during a pending load-use stall, second redirect ignored
        issue(5'd7, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1);
        cyc(1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);
        // reset in the middle of a flush window
        issue(5'd5, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
        cyc(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);
        // randomized traffic on a small register set to provoke collisions
        r1 = '0; r2 = '0; rd = '0; u1 = 1'b0; u2 = 1'b0; v = 1'b0; rw = 1'b0; ld = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!m_stall) begin
                v  = ($urandom_range(0, 4) != 0);
                r1 = AW'($urandom_range(0, 3));
                r2 = AW'($urandom_range(0, 3));
                rd = AW'($urandom_range(0, 3));
                u1 = ($urandom_range(0, 3) != 0);
                u2 = ($urandom_range(0, 1) != 0);
                rw = ($urandom_range(0, 4) != 0);
                ld = ($urandom_range(0, 2) == 0);
            end
            cyc(v, r1, u1, r2, u2, rd, rw, ld, ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 99) != 0));
        end
        idle(2);
        repeat (2) @(negedge clk);
        #4;
        chk("drain", t, 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline. It replaces the separate per-stage forwarding, stall, branch-hazard and jump-flush units with a single block. The block keeps an internal scoreboard of in-flight destination registers, drives registered forwarding selects into the EX operand muxes, and generates load-use stalls and branch/jump flushes. Forwarding depth, load latency and redirect penalty are parameters.

Parameters:
REG_AW, 5, register address width (1 << REG_AW architectural registers; x0 is never a hazard)
FWD_STAGES, 3, scoreboard depth: stages after ID (EX, MEM, WB, ...) tracked; minimum 2
LOAD_LAT, 2, first scoreboard index (0 = EX) at which load data can be forwarded
BR_PENALTY, 2, bubbles inserted on an EX redirect; minimum 1

Ports:
clk  in  1  clock
reset  in  1  synchronous active-low reset
id_valid  in  1  ID holds a valid instruction
id_rs1  in  REG_AW  ID source 1
id_rs2  in  REG_AW  ID source 2
id_rs1_used  in  1  rs1 is read by the ID instruction
id_rs2_used  in  1  rs2 is read by the ID instruction
id_rd  in  REG_AW  ID destination
id_rw  in  1  ID instruction writes rd
id_is_load  in  1  ID instruction is a load
ex_redirect  in  1  branch taken or jump resolved in EX this cycle
stall_o  out  1  hold PC and IF/ID; bubble into ID/EX
flush_o  out  1  squash IF/ID and ID/EX contents
fwd_sel_a_ex  out  $clog2(FWD_STAGES+1)  EX operand A source: 0 = regfile, k = scoreboard stage k
fwd_sel_b_ex  out  $clog2(FWD_STAGES+1)  same, operand B

Behaviour:
- Reset: synchronous, active-low, sampled on the clk rising edge.
  - All scoreboard entries invalid; flush counter 0.
  - fwd_sel_a_ex = fwd_sel_b_ex = 0; stall_o = flush_o = 0.
- Scoreboard: entry s[i] = {valid, rd, is_load} for stage i (0 = EX).
  - Every cycle: s[i+1] <= s[i], and s[FWD_STAGES-1] is dropped.
  - s[0] loads the ID instruction when id_valid & ~stall_o & ~flush_o; otherwise s[0] loads a bubble (valid = 0).
  - valid = id_rw & (id_rd != 0).
- Match, per source: the source is used, nonzero, and equal to s[j].rd with s[j].valid, for j = 0 .. FWD_STAGES-2. The nearest match (smallest j) wins.
- EX-time stage of a match = j+1. Registered select: fwd_sel_*_ex <= j+2 on a match, else 0.
- Sources older than s[FWD_STAGES-2] come from the register file, which is write-through.
- Load-use stall, combinational: stall_o = id_valid & ~flush_o & (a source's nearest match is a load with j+1 < LOAD_LAT).
  - While stalled, the selects register 0 (bubble), the instruction stays in ID and is re-evaluated each cycle.
  - The stall length is LOAD_LAT-(j+1) cycles.
- Redirect flush: flush_o = ex_redirect | (flush_cnt != 0).
  - On ex_redirect with flush_cnt == 0: flush_cnt <= BR_PENALTY-1.
  - While flush_cnt != 0: flush_cnt decrements and ex_redirect is ignored, because the EX contents are squashed.
  - Flush has priority over stall; stall_o = 0 whenever flush_o = 1.
- On the first cycle after reset deasserts, behave as an empty pipeline.
- A reset asserted mid-stall or mid-flush clears everything in that cycle.
- Same register used as rs1 and rs2: both selects must be identical.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: adds two outputs, perf_stall_cnt [31:0] and perf_flush_cnt [31:0].
  - perf_stall_cnt increments on each cycle with stall_o = 1.
  - perf_flush_cnt increments on each cycle with flush_o = 1.
  - Both wrap at 2^32 and clear on reset.
- Undefined: neither port nor counter exists.
- Core behaviour is identical in both cases.

Test Plan:
1. ALU-ALU back-to-back: issue add x5, then sub x6 using x5 as rs1 -> next cycle fwd_sel_a_ex = 2, fwd_sel_b_ex = 0, stall_o never asserted.
2. Distance-2 dependency: x5 producer, one independent instruction, then consumer using x5 as rs2 -> fwd_sel_b_ex = 3. At distance 3 -> select 0 (regfile).
3. Load-use with LOAD_LAT = 2: lw x7 followed immediately by an add reading x7 -> stall_o = 1 for exactly 1 cycle, then fwd_sel = 3. Same test with LOAD_LAT = 1 -> no stall, fwd_sel = 2.
4. x0 and unused-source filter: producer writes x0, consumer reads x0; also id_rs2_used = 0 with an id_rs2 that matches -> both selects 0, no stall.
5. Redirect: ex_redirect pulse during a pending load-use stall -> flush_o = 1 for 2 cycles (BR_PENALTY = 2), stall_o = 0, no scoreboard entries inserted. A second ex_redirect in cycle 2 is ignored.
6. Reset mid-flush: drive reset = 0 during flush_cnt = 1 -> next edge all outputs 0, scoreboard empty. With HAZ_PERF_CNT_EN, the counters read 0.
